instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 12'h000: program counter value after reset.
REQ-002 Parameter HALT_WORD, default 16'hF000: instruction word that halts fetch once it is accepted.
REQ-003 Clocking is one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begins fetching from the current PC when sampled high in IDLE.
REQ-007 jump  input  1  loads PC from jump_addr; has priority over all other events.
REQ-008 jump_addr  input  12  jump target address.
REQ-009 addIM  output  12  registered address to instmem.
REQ-010 outIM  input  16  instmem read data, valid one cycle after addIM is sampled.
REQ-011 instr_out  output  16  fetched instruction word.
REQ-012 instr_valid  output  1  instr_out and pc_out are valid.
REQ-013 instr_ready  input  1  consumer accepts the word; a transfer is instr_valid & instr_ready at a rising edge.
REQ-014 pc_out  output  12  address the current instr_out was fetched from.
REQ-015 halted  output  1  high while in HALTED.
REQ-016 fetch_count  output  16  number of accepted transfers since reset.

Function
REQ-017 The block SHALL implement five states: IDLE, ISSUE, CAPTURE, PRESENT and HALTED.
REQ-018 IDLE SHALL be the reset state; start=1 moves to ISSUE, otherwise the block stays in IDLE.
REQ-019 ISSUE SHALL drive addIM=PC for one cycle, then move to CAPTURE.
REQ-020 CAPTURE SHALL register outIM into instr_out and addIM into pc_out, then move to PRESENT.
REQ-021 instr_valid SHALL be 1 only in PRESENT; first valid occurs 3 edges after start is sampled; peak throughput is one word per 3 cycles.
REQ-022 In PRESENT with instr_ready=0, instr_out, pc_out, addIM and instr_valid SHALL hold stable indefinitely.
REQ-023 On a transfer, PC SHALL become pc_out+1 modulo 4096 (12'hFFF wraps to 12'h000), and the next state SHALL be HALTED if instr_out==HALT_WORD, else ISSUE.
REQ-024 fetch_count SHALL increment on every transfer and saturate at 16'hFFFF.
REQ-025 In HALTED, instr_valid=0 and halted=1; start SHALL be ignored; only jump or rst leaves HALTED.
REQ-026 jump=1 in ISSUE, CAPTURE, PRESENT or HALTED SHALL set PC=jump_addr, clear halted and instr_valid at the next edge, and go to ISSUE; any in-flight read is discarded.
REQ-027 jump=1 in IDLE SHALL load PC=jump_addr and stay in IDLE, unless start=1 in the same cycle, in which case the block goes to ISSUE with PC=jump_addr.
REQ-028 jump and a transfer in the same cycle: the transfer SHALL count in fetch_count; PC SHALL take jump_addr; HALT_WORD SHALL be ignored.
REQ-029 addIM SHALL hold its last value outside ISSUE; the block never writes instmem.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, PC=RESET_PC, addIM=RESET_PC, instr_out=0, pc_out=0, instr_valid=0, halted=0, fetch_count=0.
REQ-031 Reset asserted mid-operation (any state) SHALL discard any pending fetch; after release the block waits in IDLE for start.

Verification
(instmem preloaded with addr0=16'h0234, addr1=16'h0381, addr2=16'hF000.)
REQ-032 Reset, start pulse, instr_ready=1 -> the bench SHALL see (16'h0234, pc 0), (16'h0381, pc 1), (16'hF000, pc 2), each valid 3 cycles apart; then halted=1, fetch_count=3, instr_valid=0.
REQ-033 instr_ready=0 for 5 cycles while 16'h0234 is presented -> the bench SHALL see instr_out=16'h0234, pc_out=0, addIM=0 stable throughout; then 16'h0381 follows 3 cycles after acceptance.
REQ-034 jump=1, jump_addr=12'h002 while 16'h0234 is presented -> the bench SHALL see instr_valid=0 the next cycle, then instr_out=16'hF000 with pc_out=2.
REQ-035 jump to 12'hFFF, then accept that word -> the bench SHALL see addIM=12'h000 on the following ISSUE (wrap-around).
REQ-036 rst asserted between clock edges during CAPTURE -> the bench SHALL see all outputs at reset values before the next edge, and no instr_valid until a new start.
REQ-037 In HALTED, start=1 -> no change; then jump_addr=12'h000 with jump=1 -> halted=0, and 16'h0234 is presented again with fetch_count continuing from 3.

Source files
------------

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: control, instruction-memory and consumer signals of the fetch unit.
interface instr_fetch_if;
   logic        start;
   logic        jump;
   logic [11:0] jump_addr;
   logic [11:0] addIM;
   logic [15:0] outIM;
   logic [15:0] instr_out;
   logic        instr_valid;
   logic        instr_ready;
   logic [11:0] pc_out;
   logic        halted;
   logic [15:0] fetch_count;
   modport slave (
      input  start, jump, jump_addr, outIM, instr_ready,
      output addIM, instr_out, instr_valid, pc_out, halted, fetch_count
   );
   modport master (
      output start, jump, jump_addr, outIM, instr_ready,
      input  addIM, instr_out, instr_valid, pc_out, halted, fetch_count
   );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetcher with a valid/ready output,
// jump redirection and a halt word that stops fetching.
module instr_fetch #(
   parameter logic [11:0] RESET_PC  = 12'h000,
   parameter logic [15:0] HALT_WORD = 16'hF000
) (
   input logic           clk,
   input logic           rst,
   instr_fetch_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, PRESENT, HALTED} state_t;
   state_t      state_q, state_d;
   logic [11:0] pc_q, pc_d, addr_q, addr_d, pc_out_q, pc_out_d;
   logic [15:0] instr_q, instr_d, count_q, count_d;
   logic        xfer;
   assign xfer            = state_q == PRESENT && bus.instr_ready;
   assign bus.addIM       = addr_q;
   assign bus.instr_out   = instr_q;
   assign bus.pc_out      = pc_out_q;
   assign bus.instr_valid = state_q == PRESENT;
   assign bus.halted      = state_q == HALTED;
   assign bus.fetch_count = count_q;
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      count_d  = (xfer && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
      if (bus.jump) begin
         pc_d    = bus.jump_addr;
         state_d = (state_q == IDLE && !bus.start) ? IDLE : ISSUE;
      end else begin
         case (state_q)
            IDLE:    state_d = bus.start ? ISSUE : IDLE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
               instr_d  = bus.outIM;
               pc_out_d = addr_q;
               state_d  = PRESENT;
            end
            PRESENT: if (xfer) begin
               pc_d    = pc_out_q + 12'd1;
               state_d = (instr_q == HALT_WORD) ? HALTED : ISSUE;
            end
            default: state_d = state_q;
         endcase
      end
      // the address goes out on entry to ISSUE so read data lands by CAPTURE
      if (state_d == ISSUE) addr_d = pc_d;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         instr_q  <= 16'h0000;
         pc_out_q <= 12'h000;
         count_q  <= 16'h0000;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios for instr_fetch against a synchronous instmem model.
module tb_instr_fetch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   instr_fetch_if bus ();
   instr_fetch dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [15:0] mem_rd(input logic [11:0] a);
      return (a == 12'h000) ? 16'h0234 : (a == 12'h001) ? 16'h0381 :
             (a == 12'h002) ? 16'hF000 : {4'h5, a};
   endfunction
   always_ff @(posedge clk) bus.outIM <= mem_rd(bus.addIM);
   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask
   task automatic expect_word(input string nm, input logic [15:0] w, input logic [11:0] p);
      n_tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr_out !== w || bus.pc_out !== p) begin
         n_fail++;
         $display("FAIL %s: valid=%b instr=%h pc=%h, required valid=1 instr=%h pc=%h",
                  nm, bus.instr_valid, bus.instr_out, bus.pc_out, w, p);
      end
   endtask
   task automatic test_reset;
      bus.start = 0; bus.jump = 0; bus.jump_addr = 0; bus.instr_ready = 0;
      step(2);
      n_tests++;
      if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b0 || bus.addIM !== 12'h000 ||
          bus.instr_out !== 16'h0 || bus.pc_out !== 12'h0 || bus.fetch_count !== 16'h0) begin
         n_fail++;
         $display("FAIL reset: valid=%b halted=%b addIM=%h instr=%h pc=%h cnt=%h, required all zero",
                  bus.instr_valid, bus.halted, bus.addIM, bus.instr_out, bus.pc_out, bus.fetch_count);
      end
      rst = 0;
      step(1);
   endtask
   task automatic test_fetch_halt;
      bus.instr_ready = 1; bus.start = 1;
      step(1);
      bus.start = 0;
      n_tests++;
      if (bus.instr_valid !== 1'b0) begin
         n_fail++; $display("FAIL early_valid: valid=%b required 0", bus.instr_valid);
      end
      step(2); expect_word("word0", 16'h0234, 12'h000);
      step(1);
      n_tests++;
      if (bus.instr_valid !== 1'b0) begin
         n_fail++; $display("FAIL gap_valid: valid=%b required 0", bus.instr_valid);
      end
      step(2); expect_word("word1", 16'h0381, 12'h001);
      step(3); expect_word("word2", 16'hF000, 12'h002);
      step(1);
      n_tests++;
      if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.fetch_count !== 16'd3) begin
         n_fail++;
         $display("FAIL halt: halted=%b valid=%b cnt=%0d, required 1 0 3",
                  bus.halted, bus.instr_valid, bus.fetch_count);
      end
   endtask
   task automatic test_halted;
      bus.start = 1;
      step(3);
      bus.start = 0;
      n_tests++;
      if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.fetch_count !== 16'd3) begin
         n_fail++;
         $display("FAIL halt_start: halted=%b valid=%b cnt=%0d, required 1 0 3",
                  bus.halted, bus.instr_valid, bus.fetch_count);
      end
      bus.instr_ready = 0; bus.jump = 1; bus.jump_addr = 12'h000;
      step(1);
      bus.jump = 0;
      n_tests++;
      if (bus.halted !== 1'b0 || bus.addIM !== 12'h000) begin
         n_fail++;
         $display("FAIL unhalt: halted=%b addIM=%h, required 0 000", bus.halted, bus.addIM);
      end
      step(2); expect_word("rehalt_word0", 16'h0234, 12'h000);
      n_tests++;
      if (bus.fetch_count !== 16'd3) begin
         n_fail++; $display("FAIL rehalt_cnt: cnt=%0d required 3", bus.fetch_count);
      end
   endtask
   task automatic test_stall;
      for (int i = 0; i < 5; i++) begin
         step(1);
         expect_word("stall", 16'h0234, 12'h000);
         n_tests++;
         if (bus.addIM !== 12'h000) begin
            n_fail++; $display("FAIL stall_addr: addIM=%h required 000", bus.addIM);
         end
      end
      bus.instr_ready = 1;
      step(1);
      bus.instr_ready = 0;
      n_tests++;
      if (bus.fetch_count !== 16'd4 || bus.instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_accept: cnt=%0d valid=%b, required 4 0", bus.fetch_count, bus.instr_valid);
      end
      step(2); expect_word("after_stall", 16'h0381, 12'h001);
   endtask
   task automatic test_jump;
      bus.jump = 1; bus.jump_addr = 12'h000;
      step(1);
      bus.jump = 0;
      step(2); expect_word("jump_to0", 16'h0234, 12'h000);
      bus.jump = 1; bus.jump_addr = 12'h002;
      step(1);
      bus.jump = 0;
      n_tests++;
      if (bus.instr_valid !== 1'b0) begin
         n_fail++; $display("FAIL jump_drop: valid=%b required 0", bus.instr_valid);
      end
      step(2); expect_word("jump_to2", 16'hF000, 12'h002);
      n_tests++;
      if (bus.fetch_count !== 16'd4) begin
         n_fail++; $display("FAIL jump_cnt: cnt=%0d required 4", bus.fetch_count);
      end
   endtask
   task automatic test_jump_xfer_wrap;
      bus.instr_ready = 1; bus.jump = 1; bus.jump_addr = 12'hFFF;
      step(1);
      bus.jump = 0; bus.instr_ready = 0;
      n_tests++;
      if (bus.halted !== 1'b0 || bus.fetch_count !== 16'd5 || bus.addIM !== 12'hFFF) begin
         n_fail++;
         $display("FAIL jump_xfer: halted=%b cnt=%0d addIM=%h, required 0 5 fff",
                  bus.halted, bus.fetch_count, bus.addIM);
      end
      step(2); expect_word("word_fff", 16'h5FFF, 12'hFFF);
      bus.instr_ready = 1;
      step(1);
      bus.instr_ready = 0;
      n_tests++;
      if (bus.addIM !== 12'h000 || bus.fetch_count !== 16'd6) begin
         n_fail++;
         $display("FAIL wrap: addIM=%h cnt=%0d, required 000 6", bus.addIM, bus.fetch_count);
      end
      step(2); expect_word("wrap_word0", 16'h0234, 12'h000);
   endtask
   task automatic test_async_reset;
      bus.instr_ready = 1;
      step(2);
      #2 rst = 1;
      #1;
      n_tests++;
      if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b0 || bus.addIM !== 12'h000 ||
          bus.instr_out !== 16'h0 || bus.pc_out !== 12'h0 || bus.fetch_count !== 16'h0) begin
         n_fail++;
         $display("FAIL async_reset: valid=%b halted=%b addIM=%h instr=%h pc=%h cnt=%h, required all zero",
                  bus.instr_valid, bus.halted, bus.addIM, bus.instr_out, bus.pc_out, bus.fetch_count);
      end
      step(1);
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         n_tests++;
         if (bus.instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_valid: valid=%b required 0", bus.instr_valid);
         end
      end
      bus.instr_ready = 0; bus.start = 1;
      step(1);
      bus.start = 0;
      step(2); expect_word("restart_word0", 16'h0234, 12'h000);
   endtask
   task automatic test_idle_jump;
      rst = 1; step(1); rst = 0;
      bus.jump = 1; bus.jump_addr = 12'h001;
      step(1);
      bus.jump = 0;
      step(2);
      n_tests++;
      if (bus.instr_valid !== 1'b0 || bus.addIM !== 12'h000) begin
         n_fail++;
         $display("FAIL idle_jump: valid=%b addIM=%h, required 0 000", bus.instr_valid, bus.addIM);
      end
      bus.start = 1;
      step(1);
      bus.start = 0;
      n_tests++;
      if (bus.addIM !== 12'h001) begin
         n_fail++; $display("FAIL idle_jump_issue: addIM=%h required 001", bus.addIM);
      end
      step(2); expect_word("idle_jump_word", 16'h0381, 12'h001);
      rst = 1; step(1); rst = 0;
      bus.jump = 1; bus.start = 1; bus.jump_addr = 12'h002;
      step(1);
      bus.jump = 0; bus.start = 0;
      n_tests++;
      if (bus.addIM !== 12'h002) begin
         n_fail++; $display("FAIL jump_start: addIM=%h required 002", bus.addIM);
      end
      step(2); expect_word("jump_start_word", 16'hF000, 12'h002);
   endtask
   initial begin
      test_reset();
      test_fetch_halt();
      test_halted();
      test_stall();
      test_jump();
      test_jump_xfer_wrap();
      test_async_reset();
      test_idle_jump();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
